// File: rtl/mux_reg_sel.sv
// mux_reg_sel: W-bit, 2**SEL_W-channel multiplexer with a registered output
// and a valid/ready output handshake.
//
// Channel selection is either direct (sel) or scan, where a round-robin
// pointer walks the channels enabled in ch_en.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   din        flattened channel data; channel k = din[k*WIDTH +: WIDTH]
//   sel        channel index used in direct mode
//   mode       0 = direct, 1 = scan
//   ch_en      scan-mode channel enable mask
//   req        request to capture one sample
//   in_ready   a capture is possible this cycle (combinational)
//   out_valid  dout/dout_ch hold a sample
//   out_ready  consumer takes the sample this cycle
//   dout       captured data
//   dout_ch    index of the channel dout came from
module mux_reg_sel #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [(2**SEL_W)*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        mode,
  input  logic [(2**SEL_W)-1:0]       ch_en,
  input  logic                        req,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            dout,
  output logic [SEL_W-1:0]            dout_ch
);

  localparam int CHANNELS = 2**SEL_W;

  logic [CHANNELS-1:0][WIDTH-1:0] ch_data;
  logic [SEL_W-1:0]               ptr;
  logic [SEL_W-1:0]               cand;
  logic [SEL_W-1:0]               scan_idx;
  logic                           scan_hit;
  logic [SEL_W-1:0]               pick;
  logic                           accept;

  assign ch_data = din;

  // Round-robin search starting at ptr. The index arithmetic is SEL_W bits
  // wide, so it wraps at CHANNELS on its own.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = ptr;
    cand     = ptr;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = ptr + SEL_W'(i);
      if (!scan_hit && ch_en[cand]) begin
        scan_hit = 1'b1;
        scan_idx = cand;
      end
    end
  end

  // The output slot is free when empty or being drained this cycle; scan
  // mode with an empty mask can never produce a sample.
  assign in_ready = (!out_valid || out_ready) && (!mode || (|ch_en));
  assign accept   = req && in_ready;
  assign pick     = mode ? scan_idx : sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      dout_ch   <= '0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      dout      <= ch_data[pick];
      dout_ch   <= pick;
      if (mode) ptr <= scan_idx + 1'b1;
    end else if (out_ready) begin
      // Data is left in place after the consumer takes it.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_reg_sel.sv
module tb_mux_reg_sel;

  localparam int WIDTH = 4;
  localparam int SEL_W = 3;
  localparam int CH    = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [CH*WIDTH-1:0]   din;
  logic [SEL_W-1:0]      sel;
  logic                  mode;
  logic [CH-1:0]         ch_en;
  logic                  req;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      dout;
  logic [SEL_W-1:0]      dout_ch;

  int checks = 0;
  int errors = 0;

  mux_reg_sel #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode),
    .ch_en(ch_en), .req(req), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout), .dout_ch(dout_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [2:0]  sel;
    logic        mode;
    logic [7:0]  ch_en;
    logic        req;
    logic        ordy;
    logic        e_rdy;
    logic        e_vld;
    logic [3:0]  e_dout;
    logic [2:0]  e_ch;
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] d,
                         input logic [2:0] c);
    chk({tag, ".out_valid"}, int'(out_valid), int'(v));
    chk({tag, ".dout"}, int'(dout), int'(d));
    chk({tag, ".dout_ch"}, int'(dout_ch), int'(c));
  endtask

  function automatic vec_t mk(logic [31:0] d, logic [2:0] s, logic m,
                              logic [7:0] en, logic r, logic o, logic er,
                              logic ev, logic [3:0] ed, logic [2:0] ec);
    vec_t v;
    v.din = d; v.sel = s; v.mode = m; v.ch_en = en; v.req = r; v.ordy = o;
    v.e_rdy = er; v.e_vld = ev; v.e_dout = ed; v.e_ch = ec;
    return v;
  endfunction

  initial begin
    logic [31:0] d;
    // Channel k carries 8+k.
    d = 32'hFEDC_BA98;
    //           din sel m  ch_en       r  o  rdy vld dout  ch
    vt[0]  = mk(d, 3'd5, 0, 8'h00,      1, 1, 1,  1, 4'hD, 3'd5);
    vt[1]  = mk(d, 3'd5, 0, 8'h00,      0, 1, 1,  0, 4'hD, 3'd5);
    vt[2]  = mk(d, 3'd0, 0, 8'h00,      1, 0, 1,  1, 4'h8, 3'd0);
    vt[3]  = mk(d, 3'd3, 0, 8'h00,      1, 0, 0,  1, 4'h8, 3'd0);
    vt[4]  = mk(d, 3'd3, 0, 8'h00,      1, 1, 1,  1, 4'hB, 3'd3);
    vt[5]  = mk(d, 3'd7, 0, 8'h00,      1, 1, 1,  1, 4'hF, 3'd7);
    vt[6]  = mk(d, 3'd7, 0, 8'h00,      0, 1, 1,  0, 4'hF, 3'd7);
    vt[7]  = mk(d, 3'd0, 1, 8'b10010100, 1, 1, 1, 1, 4'hA, 3'd2);
    vt[8]  = mk(d, 3'd0, 1, 8'b10010100, 1, 1, 1, 1, 4'hC, 3'd4);
    vt[9]  = mk(d, 3'd0, 1, 8'b10010100, 1, 1, 1, 1, 4'hF, 3'd7);
    vt[10] = mk(d, 3'd0, 1, 8'b10010100, 1, 1, 1, 1, 4'hA, 3'd2);
    vt[11] = mk(d, 3'd0, 1, 8'b10010100, 1, 1, 1, 1, 4'hC, 3'd4);
    vt[12] = mk(d, 3'd0, 1, 8'b10010100, 1, 1, 1, 1, 4'hF, 3'd7);
    vt[13] = mk(d, 3'd0, 1, 8'h00,      1, 1, 0,  0, 4'hF, 3'd7);
    vt[14] = mk(d, 3'd0, 1, 8'h00,      1, 1, 0,  0, 4'hF, 3'd7);
    vt[15] = mk(d, 3'd0, 1, 8'h01,      1, 1, 1,  1, 4'h8, 3'd0);
    vt[16] = mk(d, 3'd6, 0, 8'h01,      1, 1, 1,  1, 4'hE, 3'd6);
    vt[17] = mk(d, 3'd0, 1, 8'h03,      1, 1, 1,  1, 4'h9, 3'd1);
    vt[18] = mk(d, 3'd0, 1, 8'h03,      1, 1, 1,  1, 4'h8, 3'd0);
    vt[19] = mk(d, 3'd0, 1, 8'h03,      0, 1, 1,  0, 4'h8, 3'd0);

    rst_n = 1'b0; din = d; sel = '0; mode = 1'b0; ch_en = '0;
    req = 1'b0; out_ready = 1'b1;
    #2;
    chk_out("reset0", 1'b0, 4'h0, 3'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("reset0.in_ready", int'(in_ready), 1);

    // Table: inputs applied after an edge, in_ready checked before the
    // next edge, registered outputs checked after it.
    for (int i = 0; i < 20; i++) begin
      din = vt[i].din; sel = vt[i].sel; mode = vt[i].mode;
      ch_en = vt[i].ch_en; req = vt[i].req; out_ready = vt[i].ordy;
      #1;
      chk($sformatf("v%0d.in_ready", i), int'(in_ready), int'(vt[i].e_rdy));
      tick();
      chk_out($sformatf("v%0d", i), vt[i].e_vld, vt[i].e_dout, vt[i].e_ch);
    end
    // ptr is now 1.

    // Backpressure: held sample must not follow din.
    d[20 +: 4] = 4'hA;
    din = d; mode = 1'b0; sel = 3'd5; req = 1'b1; out_ready = 1'b1;
    tick();
    chk_out("bp.cap", 1'b1, 4'hA, 3'd5);
    d[20 +: 4] = 4'h3;
    din = d; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp.in_ready", int'(in_ready), 0);
      tick();
      chk_out("bp.hold", 1'b1, 4'hA, 3'd5);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_rdy", int'(in_ready), 1);
    tick();
    chk_out("bp.new", 1'b1, 4'h3, 3'd5);
    req = 1'b0;
    tick();
    chk_out("bp.drain", 1'b0, 4'h3, 3'd5);

    // Reset mid-scan: ptr=1 so captures are ch2 then ch4.
    din = 32'hFEDC_BA98; mode = 1'b1; ch_en = 8'b1001_0100; req = 1'b1;
    tick();
    chk_out("rs.c2", 1'b1, 4'hA, 3'd2);
    tick();
    chk_out("rs.c4", 1'b1, 4'hC, 3'd4);
    req = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("rs.async", 1'b0, 4'h0, 3'd0);
    tick();
    rst_n = 1'b1;
    mode = 1'b0;
    #1;
    chk("rs.in_ready", int'(in_ready), 1);
    mode = 1'b1; req = 1'b1;
    tick();
    chk_out("rs.first", 1'b1, 4'hA, 3'd2);
    req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mux_reg_sel.md
Name: mux_reg_sel

Overview:
Parametrised W-bit, N-channel multiplexer with a registered output and a valid/ready output handshake. It succeeds the combinational 8:1 single-bit mux in the ALU datapath.
Two selection modes:
- Direct: the channel comes from the sel input.
- Scan: a round-robin pointer walks the channels enabled in ch_en.
Sits between the ALU result sources and downstream consumers that may apply backpressure.

Parameters:
WIDTH, 4, data bits per channel (>=1)
SEL_W, 3, select width; channel count CHANNELS = 2**SEL_W (local, derived)

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous reset, active low
din  input  CHANNELS*WIDTH  flattened channel inputs; channel k = din[k*WIDTH +: WIDTH]
sel  input  SEL_W  channel index used in direct mode
mode  input  1  0 = direct, 1 = scan
ch_en  input  CHANNELS  scan-mode channel enable mask; bit k enables channel k
req  input  1  request to capture one sample
in_ready  output  1  capture possible this cycle (combinational)
out_valid  output  1  dout/dout_ch hold a sample
out_ready  input  1  consumer accepts the sample this cycle
dout  output  WIDTH  captured data
dout_ch  output  SEL_W  index of the channel dout came from

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset: while rst_n=0, immediately and without a clock: out_valid=0, dout=0, dout_ch=0, scan pointer ptr=0. Applies mid-transfer too; a pending sample is discarded.
- in_ready = (!out_valid || out_ready) && (mode==0 || ch_en!=0).
- accept = req && in_ready. On an accept edge:
  - dout <= selected channel's din value;
  - dout_ch <= selected index;
  - out_valid <= 1.
- Latency: 1 cycle from the accept edge to out_valid/dout.
- Direct mode: selected index = sel. ptr is unchanged.
- Scan mode: selected index = first k with ch_en[k]=1, searching ptr, ptr+1, ... CHANNELS-1, 0, ... ptr-1 (wrap-around).
  - On accept, ptr <= (k+1) mod CHANNELS; index CHANNELS-1 wraps ptr to 0.
- Scan mode with ch_en==0: in_ready=0, req is ignored, no state change.
- mode, sel and ch_en are sampled only on the accept edge. Changes between accepts are legal and take effect at the next accept. Switching mode does not reset ptr.
- No accept and out_valid && out_ready: out_valid <= 0. dout and dout_ch hold their last values.
- No accept and out_valid && !out_ready: all outputs hold. dout must not follow din changes.
- Accept in the same cycle the consumer takes the old sample (out_valid && out_ready && req): out_valid stays 1 and the new sample replaces the old one with no bubble. Full throughput is 1 sample/cycle.
- req with in_ready=0 is not queued; the requester must hold req.
- No combinational path from din to dout. in_ready depends combinationally on out_valid, out_ready, mode and ch_en.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with no clock edge -> out_valid=0, dout=0, dout_ch=0 immediately; after release, in_ready=1 with mode=0.
- Direct capture (WIDTH=4): din ch5=4'hA, sel=5, mode=0, req for 1 cycle, out_ready=1 -> next cycle out_valid=1, dout=4'hA, dout_ch=5; cycle after, out_valid=0 and dout still 4'hA.
- Backpressure: sample held with out_ready=0, req=1, din ch5 changed to 4'h3 -> in_ready=0, dout stays 4'hA for 5 cycles; set out_ready=1 -> same cycle accept, next cycle dout=4'h3.
- Scan with wrap: mode=1, ch_en=8'b1001_0100, req=1 and out_ready=1 held for 6 cycles -> dout_ch sequence 2,4,7,2,4,7 with out_valid=1 continuously.
- Empty mask: mode=1, ch_en=0, req=1 -> in_ready=0, out_valid stays 0; set ch_en=8'h01 -> next edge captures ch0, dout_ch=0.
- Reset mid-scan: after captures of 2 and 4, pulse rst_n low -> outputs clear; with ch_en=8'b1001_0100 the first post-reset capture is ch2 (ptr back to 0).
